// File: rtl/loba_pkg.sv
// Shared mode encodings and the mode clamp for the LOBA multiplier pipeline.
package loba_pkg;

  localparam logic [1:0] LOBA_M0 = 2'd0;
  localparam logic [1:0] LOBA_M1 = 2'd1;
  localparam logic [1:0] LOBA_M2 = 2'd2;

  function automatic logic [1:0] loba_clamp_mode(input logic [1:0] mode,
                                                 input logic [1:0] max_mode);
    return (mode > max_mode) ? max_mode : mode;
  endfunction

endpackage

// File: rtl/loba_split_seg.sv
// Leading-one split of an operand into a high W-bit segment and the adjacent low W-bit segment.
module loba_split_seg #(
  parameter int unsigned N  = 16,
  parameter int unsigned W  = 4,
  parameter int unsigned EW = $clog2(N)
) (
  input  logic [N-1:0]  x,
  output logic [W-1:0]  xh,
  output logic [W-1:0]  xl,
  output logic [EW-1:0] eh,
  output logic [EW-1:0] el
);

  logic [EW-1:0] k;
  logic [N-1:0]  mask;

  always_comb begin
    k = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) k = EW'(i);
    end
    eh   = (k >= EW'(W - 1)) ? k - EW'(W - 1) : '0;
    el   = (eh >= EW'(W)) ? eh - EW'(W) : '0;
    // Bits strictly below the high segment; empty when eh is zero.
    mask = (N'(1) << eh) - N'(1);
    xh   = W'(x >> eh);
    xl   = W'((x & mask) >> el);
  end

endmodule

// File: rtl/loba_mult_pipe.sv
// Three-stage LOBA approximate multiplier summing 1, 3 or 4 segment partial products.
module loba_mult_pipe
  import loba_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned W        = 4,
  parameter int unsigned MAX_MODE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic [1:0]     out_mode
);

  localparam int unsigned EW = $clog2(N);
  localparam int unsigned SW = EW + 1;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned PN = 2 * N;
  localparam logic [1:0] MaxMode = 2'(MAX_MODE);

  logic          adv;
  logic [W-1:0]  a_h, a_l, b_h, b_l;
  logic [EW-1:0] a_eh, a_el, b_eh, b_el;

  logic          v1_q;
  logic [W-1:0]  ah_q, al_q, bh_q, bl_q;
  logic [EW-1:0] eha_q, ela_q, ehb_q, elb_q;
  logic [1:0]    m1_q;

  logic          v2_q;
  logic [PW-1:0] p_hh_q, p_hl_q, p_lh_q, p_ll_q;
  logic [PW-1:0] p_hh_d, p_hl_d, p_lh_d, p_ll_d;
  logic [SW-1:0] s_hh_q, s_hl_q, s_lh_q, s_ll_q;
  logic [SW-1:0] s_hh_d, s_hl_d, s_lh_d, s_ll_d;
  logic [1:0]    m2_q;
  logic [PN-1:0] sum_d;

  // The whole pipe moves in lockstep; a stalled output freezes every stage.
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;

  loba_split_seg #(.N(N), .W(W), .EW(EW)) u_split_a (
    .x  (in_a),
    .xh (a_h),
    .xl (a_l),
    .eh (a_eh),
    .el (a_el)
  );

  loba_split_seg #(.N(N), .W(W), .EW(EW)) u_split_b (
    .x  (in_b),
    .xh (b_h),
    .xl (b_l),
    .eh (b_eh),
    .el (b_el)
  );

  always_comb begin
    p_hh_d = PW'(ah_q) * PW'(bh_q);
    p_hl_d = '0;
    p_lh_d = '0;
    p_ll_d = '0;
    // Constant MAX_MODE guards let synthesis drop unused multipliers.
    if (MAX_MODE >= 1 && m1_q >= LOBA_M1) begin
      p_hl_d = PW'(ah_q) * PW'(bl_q);
      p_lh_d = PW'(al_q) * PW'(bh_q);
    end
    if (MAX_MODE >= 2 && m1_q >= LOBA_M2) begin
      p_ll_d = PW'(al_q) * PW'(bl_q);
    end
    s_hh_d = SW'(eha_q) + SW'(ehb_q);
    s_hl_d = SW'(eha_q) + SW'(elb_q);
    s_lh_d = SW'(ela_q) + SW'(ehb_q);
    s_ll_d = SW'(ela_q) + SW'(elb_q);
    sum_d  = (PN'(p_hh_q) << s_hh_q) + (PN'(p_hl_q) << s_hl_q)
           + (PN'(p_lh_q) << s_lh_q) + (PN'(p_ll_q) << s_ll_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      ah_q      <= '0;
      al_q      <= '0;
      bh_q      <= '0;
      bl_q      <= '0;
      eha_q     <= '0;
      ela_q     <= '0;
      ehb_q     <= '0;
      elb_q     <= '0;
      m1_q      <= LOBA_M0;
      v2_q      <= 1'b0;
      p_hh_q    <= '0;
      p_hl_q    <= '0;
      p_lh_q    <= '0;
      p_ll_q    <= '0;
      s_hh_q    <= '0;
      s_hl_q    <= '0;
      s_lh_q    <= '0;
      s_ll_q    <= '0;
      m2_q      <= LOBA_M0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_mode  <= LOBA_M0;
    end else if (adv) begin
      v1_q      <= in_valid;
      ah_q      <= a_h;
      al_q      <= a_l;
      bh_q      <= b_h;
      bl_q      <= b_l;
      eha_q     <= a_eh;
      ela_q     <= a_el;
      ehb_q     <= b_eh;
      elb_q     <= b_el;
      m1_q      <= loba_clamp_mode(in_mode, MaxMode);
      v2_q      <= v1_q;
      p_hh_q    <= p_hh_d;
      p_hl_q    <= p_hl_d;
      p_lh_q    <= p_lh_d;
      p_ll_q    <= p_ll_d;
      s_hh_q    <= s_hh_d;
      s_hl_q    <= s_hl_d;
      s_lh_q    <= s_lh_d;
      s_ll_q    <= s_ll_d;
      m2_q      <= m1_q;
      out_valid <= v2_q;
      out_p     <= sum_d;
      out_mode  <= m2_q;
    end
  end

endmodule

// File: doc/loba_mult_pipe.md
Name: loba_mult_pipe

Overview:
- Parametrised, pipelined successor to the combinational single-term LOBA approximate multiplier.
- Each operand splits at its leading one into a high W-bit segment and the adjacent low W-bit segment.
- Sums 1, 3 or 4 segment partial products, selected per transaction by a runtime mode.
- Sits between operand producers and the accumulate datapath; uses a valid/ready handshake on both sides and carries full backpressure.

Parameters:
- N, 16, operand width in bits (N >= 2*W).
- W, 4, segment width in bits.
- MAX_MODE, 2, highest mode that has hardware (0..2); requested modes above it are clamped to MAX_MODE.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands.
- in_a  in  N  operand A, unsigned.
- in_b  in  N  operand B, unsigned.
- in_mode  in  2  0 = Ah*Bh; 1 = add Ah*Bl + Al*Bh; 2/3 = also add Al*Bl.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_p  out  2N  approximate product, unsigned.
- out_mode  out  2  effective (clamped) mode used for out_p.

Behaviour:
- Reset: synchronous, active-low; all stage valids clear. Under reset, out_valid=0, out_p=0, out_mode=0 and in_ready=1 from the first cycle after reset is sampled.
- Split, per operand X:
  - k = index of the leading one.
  - eh = max(k-W+1, 0); Xh = (X >> eh) mod 2^W.
  - el = max(eh-W, 0); Xl = ((X mod 2^eh) >> el) mod 2^W, where mod 2^0 = 0.
  - X=0 gives Xh=Xl=0, eh=el=0.
- Product: out_p = Ah*Bh<<(eha+ehb)
  - + [mode>=1] (Ah*Bl<<(eha+elb) + Al*Bh<<(ela+ehb))
  - + [mode>=2] Al*Bl<<(ela+elb).
  - All terms are non-negative shifts. The sum never exceeds exact A*B, so it always fits in 2N bits and needs no saturation.
- Effective mode = min(in_mode, MAX_MODE), captured with the operands.
- Pipeline:
  - S1 registers the split (segments, exponents, mode).
  - S2 registers the partial products and exponent sums.
  - S3 registers shift-and-add into out_p/out_mode.
  - Latency is 3 cycles from the accepting edge to out_valid when there is no stall. Throughput is 1 per cycle.
- Handshake:
  - Transfer on the input side occurs when in_valid&in_ready.
  - Transfer on the output side occurs when out_valid&out_ready.
  - in_ready = !out_valid | out_ready: the whole pipe advances together; bubbles are not collapsed.
  - While out_valid&!out_ready, out_p/out_mode/out_valid hold stable and no stage advances.
  - in_a/in_b/in_mode are don't-care when not transferring.
- Simultaneous input and output transfer in one cycle is legal; sustained full throughput must hold with out_ready=1.
- Reset mid-operation drops all in-flight results; no output follows for operands accepted before reset.
- Hardware for modes above MAX_MODE is not built, and the clamp is visible on out_mode.

Decomposition:
- Package loba_pkg holds the mode encodings (LOBA_M0, LOBA_M1, LOBA_M2) and a function computing the clamped mode.
- One sub-module, loba_split_seg (parametrised N, W): combinational leading-one detect producing Xh, Xl, eh, el. It is instantiated twice in S1.
- Remaining logic is inline.

Test Plan:
- A=0x00F0, B=0x00F0, mode 0 -> out_p=0x0000E100 (exact), out_valid exactly 3 cycles after accept.
- A=0x1234, B=0x0003, mode 0 -> 0x00003600; mode 1 -> 0x00003660; mode 2 -> 0x00003660.
- A=0xFFFF, B=0xFFFF: mode 0 -> 0xE1000000; mode 2 -> 0xFE010000; mode 3 -> 0xFE010000 with out_mode=2. MAX_MODE=0 build, mode 2 -> 0xE1000000 with out_mode=0.
- A=0, B=0xBEEF, any mode -> out_p=0. A=1, B=1 -> out_p=1.
- Back-to-back stream of 8 operands:
  - hold out_ready=0 for 5 cycles mid-stream -> in_ready deasserts, out_p stays stable.
  - all 8 results arrive in order with no loss or duplication.
  - with out_ready=1 throughout -> one result per cycle.
- Assert rst_n=0 for 1 cycle with 3 transactions in flight -> out_valid=0 and out_p=0 next cycle, no stale results after release.
